// File: rtl/dsp_reset_sequencer.sv
// dsp_reset_sequencer: arbitrates DSP reset sources and sequences assert, boot blanking, run and lockout.
module dsp_reset_sequencer #(
  parameter int RST_HOLD    = 19999,
  parameter int BOOT_BLANK  = 199999,
  parameter int STABLE_TIME = 1999999,
  parameter int MAX_RETRY   = 3
) (
  input  logic       clk_20M,
  input  logic       reset,
  input  logic       pwr_ok,
  input  logic       wd_err,
  input  logic       sw_req,
  input  logic       clear_lockout,
  output logic       dsp_rst,
  output logic       wd_enable,
  output logic       busy,
  output logic       lockout,
  output logic [1:0] rst_cause,
  output logic [3:0] retry_cnt
);
  typedef enum logic [1:0] {S_ASSERT, S_BOOT, S_RUN, S_LOCKOUT} state_t;
  localparam logic [23:0] L_HOLD   = 24'(RST_HOLD);
  localparam logic [23:0] L_BLANK  = 24'(BOOT_BLANK);
  localparam logic [23:0] L_STABLE = 24'(STABLE_TIME);
  localparam logic [3:0]  L_MAX    = 4'(MAX_RETRY);
  state_t      r_state, w_state_n;
  logic [23:0] r_cnt, w_cnt_n, r_scnt, w_scnt_n;
  logic [1:0]  w_cause_n;
  logic [3:0]  w_retry_n, w_retry_inc;
  logic        r_wd_q, w_wd_rise;
  assign w_wd_rise   = wd_err & ~r_wd_q;
  assign w_retry_inc = (retry_cnt == 4'hF) ? retry_cnt : retry_cnt + 4'd1;
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_scnt_n  = r_scnt;
    w_cause_n = rst_cause;
    w_retry_n = retry_cnt;
    case (r_state)
      S_ASSERT:
        if (!pwr_ok) begin
          w_cnt_n   = '0;
          w_cause_n = 2'd3;
        end else if (r_cnt == L_HOLD) begin
          w_state_n = S_BOOT;
          w_cnt_n   = '0;
        end else
          w_cnt_n = r_cnt + 24'd1;
      S_BOOT:
        if (!pwr_ok) begin
          w_state_n = S_ASSERT;
          w_cnt_n   = '0;
          w_cause_n = 2'd3;
        end else if (r_cnt == L_BLANK) begin
          w_state_n = S_RUN;
          w_cnt_n   = '0;
          w_scnt_n  = '0;
        end else
          w_cnt_n = r_cnt + 24'd1;
      S_RUN: begin
        w_scnt_n = (r_scnt == L_STABLE) ? r_scnt : r_scnt + 24'd1;
        if (!pwr_ok) begin
          w_state_n = S_ASSERT;
          w_cnt_n   = '0;
          w_cause_n = 2'd3;
        end else if (sw_req) begin
          w_state_n = S_ASSERT;
          w_cnt_n   = '0;
          w_cause_n = 2'd2;
        end else if (w_wd_rise) begin
          w_state_n = (w_retry_inc >= L_MAX) ? S_LOCKOUT : S_ASSERT;
          w_cnt_n   = '0;
          w_cause_n = 2'd1;
          w_retry_n = w_retry_inc;
        end else if (w_scnt_n == L_STABLE && r_scnt != L_STABLE)
          w_retry_n = '0;
      end
      S_LOCKOUT:
        if (clear_lockout) begin
          w_state_n = S_ASSERT;
          w_cnt_n   = '0;
          w_cause_n = 2'd2;
          w_retry_n = '0;
        end
      default: w_state_n = S_ASSERT;
    endcase
  end
  always_ff @(posedge clk_20M) begin
    if (reset) begin
      r_state   <= S_ASSERT;
      r_cnt     <= '0;
      r_scnt    <= '0;
      r_wd_q    <= 1'b0;
      dsp_rst   <= 1'b1;
      wd_enable <= 1'b0;
      busy      <= 1'b1;
      lockout   <= 1'b0;
      rst_cause <= 2'd0;
      retry_cnt <= 4'd0;
    end else begin
      r_state   <= w_state_n;
      r_cnt     <= w_cnt_n;
      r_scnt    <= w_scnt_n;
      r_wd_q    <= wd_err;
      dsp_rst   <= (w_state_n == S_ASSERT) || (w_state_n == S_LOCKOUT);
      wd_enable <= (w_state_n == S_RUN);
      busy      <= (w_state_n == S_ASSERT) || (w_state_n == S_BOOT);
      lockout   <= (w_state_n == S_LOCKOUT);
      rst_cause <= w_cause_n;
      retry_cnt <= w_retry_n;
    end
  end
endmodule
